// File: rtl/decomp_pkg.sv
// Shared definitions for the bitmap-coded stream decompressor:
// per-word code encoding and the number of stream bytes each code consumes.
package decomp_pkg;

   typedef enum logic [1:0] {
      CODE_ZERO = 2'b00,
      CODE_Q    = 2'b01,
      CODE_H    = 2'b10,
      CODE_W    = 2'b11
   } code_e;

   function automatic int unsigned need_bytes(input code_e code, input int unsigned word_w);
      case (code)
         CODE_ZERO: need_bytes = 0;
         CODE_Q:    need_bytes = word_w / 32;
         CODE_H:    need_bytes = word_w / 16;
         CODE_W:    need_bytes = word_w / 8;
         default:   need_bytes = 0;
      endcase
   endfunction

endpackage

// File: rtl/decomp_expand.sv
// Combinational field expansion: widens the low bytes of the staging buffer
// to a full output word according to the per-word code.
module decomp_expand
   import decomp_pkg::*;
#(
   parameter int WORD_W   = 32,
   parameter int SIGN_EXT = 1
) (
   input  code_e             code_i,
   input  logic [WORD_W-1:0] raw_i,
   output logic [WORD_W-1:0] word_o
);

   localparam int Q_W = WORD_W / 4;
   localparam int H_W = WORD_W / 2;

   // Keep the low nbits of raw and fill the rest with sign or zero bits.
   function automatic logic [WORD_W-1:0] extend(input logic [WORD_W-1:0] raw,
                                                input int unsigned nbits);
      logic [WORD_W-1:0] mask;
      mask   = {WORD_W{1'b1}} >> (WORD_W - nbits);
      extend = raw & mask;
      if ((SIGN_EXT != 0) && raw[nbits-1]) extend = extend | ~mask;
   endfunction

   always_comb begin
      word_o = '0;
      case (code_i)
         CODE_ZERO: word_o = '0;
         CODE_Q:    word_o = extend(raw_i, Q_W);
         CODE_H:    word_o = extend(raw_i, H_W);
         CODE_W:    word_o = raw_i;
         default:   word_o = '0;
      endcase
   end

endmodule

// File: rtl/stream_decompressor.sv
// Bitmap-coded stream decompressor: packed compressed bytes are staged in a
// small byte buffer and expanded one output word per accepted code.
module stream_decompressor
   import decomp_pkg::*;
#(
   parameter int WORD_W   = 32,
   parameter int IN_BYTES = 4,
   parameter int SIGN_EXT = 1,
   localparam int BUF_BYTES = WORD_W / 8 + IN_BYTES,
   localparam int FILL_W    = $clog2(BUF_BYTES + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  code_valid,
   output logic                  code_ready,
   input  logic [1:0]            code,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*IN_BYTES-1:0] in_data,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_W-1:0]     out_data,
   output logic [FILL_W-1:0]     fill
);

   localparam int BUF_W = 8 * BUF_BYTES;

   logic [BUF_W-1:0]  buf_q, buf_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              out_valid_q, out_valid_d;
   logic [WORD_W-1:0] out_data_q, out_data_d;
   logic [WORD_W-1:0] expanded;
   code_e             code_in;
   logic [FILL_W-1:0] need, consumed, remaining;
   logic              code_hs, in_hs;
   logic [BUF_W-1:0]  shifted, incoming;

   assign code_in    = code_e'(code);
   assign need       = FILL_W'(need_bytes(code_in, WORD_W));
   assign in_ready   = (fill_q <= FILL_W'(BUF_BYTES - IN_BYTES));
   assign code_ready = code_valid && (fill_q >= need) && (!out_valid_q || out_ready);
   assign code_hs    = code_valid && code_ready;
   assign in_hs      = in_valid && in_ready;

   decomp_expand #(
      .WORD_W   (WORD_W),
      .SIGN_EXT (SIGN_EXT)
   ) u_expand (
      .code_i (code_in),
      .raw_i  (buf_q[WORD_W-1:0]),
      .word_o (expanded)
   );

   // Bytes above fill are kept zero, so new bytes can be OR-ed in above the survivors.
   always_comb begin
      consumed  = code_hs ? need : '0;
      remaining = fill_q - consumed;
      shifted   = buf_q >> (8 * consumed);
      incoming  = BUF_W'(in_data) << (8 * remaining);
      buf_d     = shifted;
      fill_d    = remaining;
      if (flush) begin
         buf_d  = '0;
         fill_d = '0;
      end else if (in_hs) begin
         buf_d  = shifted | incoming;
         fill_d = remaining + FILL_W'(IN_BYTES);
      end

      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      if (code_hs) begin
         out_data_d  = expanded;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q       <= '0;
         fill_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         buf_q       <= buf_d;
         fill_q      <= fill_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign fill      = fill_q;

endmodule

// File: tb/tb_stream_decompressor.sv
// Self-checking bench: a byte-queue reference model predicts readiness, fill
// and output words; expected words are queued at code handshakes and popped at output handshakes.
module tb_stream_decompressor;

   logic        clk;
   logic        rst, code_valid, in_valid, flush, out_ready;
   logic [1:0]  code;
   logic [31:0] in_data;
   logic        code_ready, in_ready, out_valid;
   logic [31:0] out_data;
   logic [3:0]  fill;

   logic        z_rst, z_code_valid, z_in_valid, z_flush, z_out_ready;
   logic [1:0]  z_code;
   logic [31:0] z_in_data;
   logic        z_code_ready, z_in_ready, z_out_valid;
   logic [31:0] z_out_data;
   logic [3:0]  z_fill;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  mq[$];
   logic [31:0] sb[$];
   bit          m_ov = 0;

   stream_decompressor #(.WORD_W(32), .IN_BYTES(4), .SIGN_EXT(1)) u_dut (
      .clk(clk), .rst(rst), .code_valid(code_valid), .code_ready(code_ready), .code(code),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .fill(fill)
   );

   stream_decompressor #(.WORD_W(32), .IN_BYTES(4), .SIGN_EXT(0)) u_dut_z (
      .clk(clk), .rst(z_rst), .code_valid(z_code_valid), .code_ready(z_code_ready), .code(z_code),
      .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data), .flush(z_flush),
      .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data), .fill(z_fill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int need_of(input logic [1:0] c);
      case (c)
         2'd0:    return 0;
         2'd1:    return 1;
         2'd2:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] model_word(input logic [1:0] c, input bit se);
      logic [31:0] r;
      case (c)
         2'd0: r = 32'h0;
         2'd1: begin
            r = {24'h0, mq[0]};
            if (se && mq[0][7]) r[31:8] = '1;
         end
         2'd2: begin
            r = {16'h0, mq[1], mq[0]};
            if (se && mq[1][7]) r[31:16] = '1;
         end
         default: r = {mq[3], mq[2], mq[1], mq[0]};
      endcase
      return r;
   endfunction

   // One clock: compare against the model at the falling edge, advance the model, return #1 after the rising edge.
   task automatic step();
      int          nd;
      bit          exp_ir, exp_cr, ihs;
      logic [31:0] w;
      @(negedge clk);
      nd     = need_of(code);
      exp_ir = (mq.size() <= 4);
      exp_cr = code_valid && (mq.size() >= nd) && (!m_ov || out_ready);
      check("in_ready", 32'(in_ready), 32'(exp_ir));
      check("code_ready", 32'(code_ready), 32'(exp_cr));
      check("fill", 32'(fill), 32'(mq.size()));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
         check("sb_depth", 32'(sb.size()), 32'd1);
         if (sb.size() > 0) begin
            check("out_data", out_data, sb[0]);
            if (out_ready) void'(sb.pop_front());
         end
      end
      ihs = in_valid && exp_ir;
      if (rst) begin
         mq.delete();
         sb.delete();
         m_ov = 0;
      end else begin
         if (exp_cr) begin
            w = model_word(code, 1'b1);
            sb.push_back(w);
            for (int i = 0; i < nd; i++) void'(mq.pop_front());
         end
         if (flush) mq.delete();
         else if (ihs) for (int i = 0; i < 4; i++) mq.push_back(in_data[8*i +: 8]);
         m_ov = exp_cr ? 1'b1 : (out_ready ? 1'b0 : m_ov);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic word(input logic [1:0] c);
      code_valid = 1'b1;
      code       = c;
      step();
      code_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; code_valid = 1'b0; code = 2'd0; in_valid = 1'b0; in_data = '0;
      flush = 1'b0; out_ready = 1'b1;
      z_rst = 1'b1; z_code_valid = 1'b0; z_code = 2'd0; z_in_valid = 1'b0; z_in_data = '0;
      z_flush = 1'b0; z_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_fill", 32'(fill), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_code_ready", 32'(code_ready), 32'd0);

      // Three zero words from an empty buffer.
      code_valid = 1'b1;
      code       = 2'd0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("zero_word", out_data, 32'h0);
         check("zero_fill", 32'(fill), 32'd0);
      end
      code_valid = 1'b0;
      step();

      // Mixed codes over two beats.
      beat(32'h12345678);
      beat(32'h00FFFE80);
      code_valid = 1'b1;
      code = 2'd3; step(); check("mix_w", out_data, 32'h12345678);
      code = 2'd1; step(); check("mix_q", out_data, 32'hFFFFFF80);
      code = 2'd2; step(); check("mix_h", out_data, 32'hFFFFFFFE);
      code = 2'd0; step(); check("mix_z", out_data, 32'h00000000);
      code_valid = 1'b0;
      step();
      check("mix_fill", 32'(fill), 32'd1);

      // Stall of a full-word code with only two bytes buffered.
      do_reset();
      beat(32'hA1B2C3D4);
      word(2'd2);
      check("stall_h", out_data, 32'hFFFFC3D4);
      code_valid = 1'b1;
      code       = 2'd3;
      repeat (3) step();
      check("stall_no_out", 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_data  = 32'h55667788;
      step();
      in_valid = 1'b0;
      check("stall_still", 32'(out_valid), 32'd0);
      step();
      code_valid = 1'b0;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out", out_data, 32'h7788A1B2);
      check("stall_fill", 32'(fill), 32'd2);
      step();

      // Output back-pressure with a full buffer.
      do_reset();
      beat(32'h11111111);
      beat(32'h22222222);
      word(2'd3);
      out_ready  = 1'b0;
      code_valid = 1'b1;
      code       = 2'd3;
      in_valid   = 1'b1;
      in_data    = 32'h33333333;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_data", out_data, 32'h11111111);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_code_ready", 32'(code_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("bp_next", out_data, 32'h22222222);
      code_valid = 1'b0;
      step();

      // Reset mid-stream, then flush.
      do_reset();
      beat(32'h01020304);
      beat(32'h05060708);
      word(2'd2);
      word(2'd1);
      out_ready = 1'b0;
      step();
      check("pre_rst_fill", 32'(fill), 32'd5);
      check("pre_rst_ov", 32'(out_valid), 32'd1);
      code_valid = 1'b1; code = 2'd0; in_valid = 1'b1; in_data = 32'hDEADBEEF; flush = 1'b1;
      do_reset();
      code_valid = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      check("rst2_fill", 32'(fill), 32'd0);
      check("rst2_ov", 32'(out_valid), 32'd0);
      check("rst2_in_ready", 32'(in_ready), 32'd1);
      check("rst2_data", out_data, 32'h0);
      beat(32'h0A0B0C0D);
      word(2'd1);
      check("pre_flush_fill", 32'(fill), 32'd3);
      flush = 1'b1; in_valid = 1'b1; in_data = 32'hCAFEF00D;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_fill", 32'(fill), 32'd0);
      code_valid = 1'b1;
      code       = 2'd1;
      repeat (2) step();
      check("flush_stall", 32'(out_valid), 32'd0);
      code_valid = 1'b0;

      // Randomised traffic against the model, including flushes and resets.
      for (int i = 0; i < 400; i++) begin
         in_valid   = 1'($urandom_range(0, 1));
         in_data    = $urandom;
         code_valid = 1'($urandom_range(0, 1));
         code       = 2'($urandom_range(0, 3));
         out_ready  = ($urandom_range(0, 3) != 0);
         flush      = ($urandom_range(0, 15) == 0);
         rst        = ($urandom_range(0, 63) == 0);
         step();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; code_valid = 1'b0; out_ready = 1'b1;
      step();

      // Zero-extending instance.
      @(posedge clk);
      #1;
      z_rst = 1'b0;
      z_in_valid = 1'b1;
      z_in_data  = 32'h0000FF80;
      @(posedge clk);
      #1;
      z_in_valid   = 1'b0;
      z_code_valid = 1'b1;
      z_code       = 2'd1;
      @(negedge clk);
      check("z_code_ready", 32'(z_code_ready), 32'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("z_ov", 32'(z_out_valid), 32'd1);
      check("z_first", z_out_data, 32'h00000080);
      @(posedge clk);
      #1;
      z_code_valid = 1'b0;
      @(negedge clk);
      check("z_second", z_out_data, 32'h000000FF);
      check("z_fill", 32'(z_fill), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stream_decompressor.md
STREAM_DECOMPRESSOR -- requirements
Module: stream_decompressor

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning output word width in bits; must be a multiple of 32.
REQ-002 SHALL have parameter IN_BYTES, default 4, meaning compressed input bus width in bytes; must satisfy 1 <= IN_BYTES <= WORD_W/8.
REQ-003 SHALL have parameter SIGN_EXT, default 1, meaning short fields are sign-extended when 1 and zero-extended when 0.
REQ-004 SHALL have ports: clk input 1, rising-edge clock; rst input 1, reset (one clock; reset is synchronous and active-high).
REQ-005 SHALL have ports: code_valid input 1; code_ready output 1; code input 2, per-word bitmap code.
REQ-006 SHALL have ports: in_valid input 1; in_ready output 1; in_data input 8*IN_BYTES, packed compressed bytes with the first stream byte in bits [7:0].
REQ-007 SHALL have ports: flush input 1, discards buffered bytes; out_valid output 1; out_ready input 1; out_data output WORD_W.
REQ-008 SHALL have port: fill output, width clog2(BUF_BYTES+1), current byte-buffer occupancy, where BUF_BYTES = WORD_W/8 + IN_BYTES.

Function
REQ-009 SHALL map codes as: 00 -> 0 bytes, output zero; 01 -> WORD_W/32 bytes; 10 -> WORD_W/16 bytes; 11 -> WORD_W/8 bytes, output raw.
REQ-010 SHALL extend 01/10 fields to WORD_W per SIGN_EXT, with field byte 0 as the LSB.
REQ-011 SHALL hold bytes in a staging buffer of BUF_BYTES, consumed from the low end in stream order.
REQ-012 SHALL drive in_ready = (fill <= BUF_BYTES - IN_BYTES), from registered state only, independent of in_valid.
REQ-013 SHALL drive code_ready = code_valid && fill >= need(code) && (!out_valid || out_ready); the combinational out_ready path is permitted.
REQ-014 SHALL register the output: on a code handshake, out_data/out_valid update at the next edge, giving 1-cycle latency from code handshake to out_valid.
REQ-015 SHALL hold out_data stable while out_valid && !out_ready, and clear out_valid after an out handshake with no new code handshake.
REQ-016 SHALL update fill_next = fill - consumed + (in handshake ? IN_BYTES : 0) when consume and append occur in the same cycle, appending new bytes directly above the remaining ones.
REQ-017 SHALL accept code 00 regardless of fill, including fill = 0.
REQ-018 SHALL stall a code whose need exceeds fill, producing no output and no partial consumption, until enough bytes arrive.
REQ-019 SHALL, on flush, set fill to 0 at the next edge and ignore that cycle's in handshake bytes, while a same-cycle code 00 handshake still completes.
REQ-020 SHALL let flush leave out_valid/out_data untouched.

Reset
REQ-021 SHALL, on rst, force at the next edge: fill = 0, out_valid = 0, out_data = 0, buffer contents = 0.
REQ-022 SHALL, after reset, assert in_ready and deassert code_ready with code_valid low, with rst taking priority over flush and all handshakes, including mid-word.

Structure
REQ-023 SHALL place in shared package decomp_pkg: the 2-bit code enum (CODE_ZERO, CODE_Q, CODE_H, CODE_W) and a need_bytes(code, WORD_W) function.
REQ-024 SHALL implement field extension (REQ-009/010) in one combinational sub-module decomp_expand, parameterised by WORD_W and SIGN_EXT; the buffer and handshakes stay in stream_decompressor.

Verification (WORD_W=32, IN_BYTES=4, SIGN_EXT=1, out_ready=1 unless stated)
REQ-025 SHALL cover: beats 0x12345678, 0x00FFFE80; codes 11,01,10,00 -> out_data 0x12345678, 0xFFFFFF80, 0xFFFFFFFE, 0x00000000, final fill = 1.
REQ-026 SHALL cover: three code 00 with in_valid low from reset -> three consecutive zero outputs, fill stays 0.
REQ-027 SHALL cover: out_ready low 5 cycles with out_valid=1 -> out_data stable, code_ready=0, in_ready=0 once fill = 8.
REQ-028 SHALL cover: fill = 2, code 11 -> no output until the next beat; then output in the cycle after the code handshake, fill = 2.
REQ-029 SHALL cover: SIGN_EXT=0, beat 0x0000FF80, codes 01,01 -> 0x00000080, 0x000000FF.
REQ-030 SHALL cover: rst with fill = 5, out_valid = 1 -> next cycle fill = 0, out_valid = 0, in_ready = 1; flush with fill = 3 -> fill = 0, and a following code 01 stalls.
